hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard unit for an RR->EX->MEM->WB back end. It keeps the destination
//   writes of the instructions in EX, MEM and WB. For each source operand of
//   the instruction in RR it either raises a load-use stall or registers a
//   forward select that lines up with the instruction once it reaches EX.
//   Optional feature macro: HAZARD_PERF_EN (adds stall_cnt / fwd_cnt).
//   Forward select per source: 0 = RR/EX value, 1 = EX/MEM, 2 = MEM/WB.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NSRC     = 2,
    parameter int ZERO_REG = 1,
    parameter int PERF_W   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rr_valid,
    input  logic [NSRC*REG_AW-1:0]   rr_src,
    input  logic [NSRC-1:0]          rr_src_used,
    input  logic [REG_AW-1:0]        rr_dst,
    input  logic                     rr_wr,
    input  logic                     rr_is_load,
    input  logic                     hold,
    input  logic                     flush,
    output logic                     stall,
    output logic                     bubble,
    output logic [2*NSRC-1:0]        ex_fwd_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]        stall_cnt,
    output logic [PERF_W-1:0]        fwd_cnt
`endif
);

    typedef struct packed {
        logic              v;
        logic              wr;
        logic [REG_AW-1:0] dst;
        logic              ld;
    } hist_t;

    localparam logic [1:0] SEL_RR  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    hist_t             hist_ex;
    hist_t             hist_mem;
    hist_t             hist_wb;
    logic [NSRC-1:0]   load_use;
    logic [2*NSRC-1:0] sel_next;
    logic              issue;

    // An entry can only be forwarded from if it is a real, writing instruction.
    function automatic logic hits(input hist_t h, input logic [REG_AW-1:0] src);
        return h.v && h.wr && (h.dst == src);
    endfunction

    // Per-source match against the history; the youngest producer wins.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        load_use = '0;
        sel_next = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (rr_src_used[i] &&
                !(ZERO_REG != 0 && rr_src[i*REG_AW +: REG_AW] == '0)) begin
                if (hits(hist_ex, rr_src[i*REG_AW +: REG_AW])) begin
                    if (hist_ex.ld) begin
                        load_use[i] = 1'b1;
                    end else begin
                        sel_next[2*i +: 2] = SEL_EX;
                    end
                end else if (hits(hist_mem, rr_src[i*REG_AW +: REG_AW])) begin
                    sel_next[2*i +: 2] = SEL_MEM;
                end else if (hits(hist_wb, rr_src[i*REG_AW +: REG_AW])) begin
                    // The register file writes through in the WB cycle.
                    sel_next[2*i +: 2] = SEL_RR;
                end
            end
        end
    end

    // Pipeline control: flush overrides a stall and both become a bubble.
    always_comb begin
        stall  = rr_valid && !flush && (|load_use);
        bubble = stall || flush;
        issue  = rr_valid && !stall && !flush;
    end

    // History shift and registered forward selects; frozen while hold is high.
    // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_ex    <= '0;
            hist_mem   <= '0;
            hist_wb    <= '0;
            ex_fwd_sel <= '0;
        end else if (!hold) begin
            hist_wb  <= hist_mem;
            hist_mem <= hist_ex;
            if (issue) begin
                hist_ex    <= '{v: 1'b1, wr: rr_wr, dst: rr_dst, ld: rr_is_load};
                ex_fwd_sel <= sel_next;
            end else begin
                hist_ex    <= '0;
                ex_fwd_sel <= '0;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Performance counters: stalled cycles and issued instructions that forward.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (!hold) begin
            if (stall) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (issue && (|sel_next)) begin
                fwd_cnt <= fwd_cnt + PERF_W'(1);
            end
        end
    end
`endif

endmodule
